// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache.
//   ST_IDLE / ST_FILL / ST_WRITE : controller state encodings
//   clog2                        : ceiling log2, used for the index width
package cache_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = n - 1;
      for (int i = 0; i < 32; i++) begin
         if (v != 0) begin
            r = r + 1;
            v = v >> 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
//   g_clk  : clock
//   g_clr  : synchronous active-high clear
//   inc    : increment request for this cycle
//   count  : current count
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             g_clk,
   input  logic             g_clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge g_clk) begin
      if (g_clr) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with one-word lines.
//   cpu_*     : request side; requester holds the request until odv=1
//   odv       : request complete (read data valid on cpu_rdata for reads)
//   flush     : invalidate every line at the next edge
//   mem_*     : handshaked backing RAM; mem_rdata is valid with mem_ack
//   hit_cnt   : saturating count of read hits
//   miss_cnt  : saturating count of read misses
module dm_cache
   import cache_pkg::*;
#(
   parameter int unsigned D_WIDTH   = 16,
   parameter int unsigned A_WIDTH   = 8,
   parameter int unsigned LINES     = 4,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 g_clk,
   input  logic                 g_clr,
   input  logic [A_WIDTH-1:0]   cpu_addr,
   input  logic [D_WIDTH-1:0]   cpu_wdata,
   input  logic                 cpu_re,
   input  logic                 cpu_we,
   output logic [D_WIDTH-1:0]   cpu_rdata,
   output logic                 odv,
   input  logic                 flush,
   output logic [A_WIDTH-1:0]   mem_addr,
   output logic [D_WIDTH-1:0]   mem_wdata,
   output logic                 mem_re,
   output logic                 mem_we,
   input  logic [D_WIDTH-1:0]   mem_rdata,
   input  logic                 mem_ack,
   output logic [CNT_WIDTH-1:0] hit_cnt,
   output logic [CNT_WIDTH-1:0] miss_cnt
);

   localparam int unsigned IDX_W = clog2(LINES);
   localparam int unsigned TAG_W = A_WIDTH - IDX_W;

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [LINES-1:0] valid_q;
   logic [LINES-1:0] valid_d;

   // Tag and data arrays carry no reset; valid bits gate their use.
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [D_WIDTH-1:0] data_q [LINES];

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic             line_hit;
   logic             fill_we;
   logic             data_we;
   logic             hit_inc;
   logic             miss_inc;

   assign idx      = cpu_addr[IDX_W-1:0];
   assign tag      = cpu_addr[A_WIDTH-1:IDX_W];
   assign line_hit = valid_q[idx] && (tag_q[idx] == tag);

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      odv       = 1'b0;
      cpu_rdata = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      fill_we   = 1'b0;
      data_we   = 1'b0;
      hit_inc   = 1'b0;
      miss_inc  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A write wins when both strobes are high.
            if (cpu_we) begin
               state_d = ST_WRITE;
            end else if (cpu_re) begin
               if (line_hit) begin
                  odv       = 1'b1;
                  cpu_rdata = data_q[idx];
                  hit_inc   = 1'b1;
               end else begin
                  miss_inc = 1'b1;
                  state_d  = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            mem_re   = 1'b1;
            mem_addr = cpu_addr;
            if (mem_ack) begin
               odv          = 1'b1;
               cpu_rdata    = mem_rdata;
               fill_we      = 1'b1;
               valid_d[idx] = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         ST_WRITE: begin
            mem_we    = 1'b1;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            if (mem_ack) begin
               odv     = 1'b1;
               data_we = line_hit;  // no write-allocate on a miss
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Flush beats a completing fill: data goes out but the line stays invalid.
      if (flush) begin
         valid_d = '0;
      end
   end

   always_ff @(posedge g_clk) begin
      if (g_clr) begin
         state_q <= ST_IDLE;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
      end
   end

   // Line storage; a reset at the completing edge abandons the update.
   always_ff @(posedge g_clk) begin
      if (!g_clr) begin
         if (fill_we) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= mem_rdata;
         end else if (data_we) begin
            data_q[idx] <= cpu_wdata;
         end
      end
   end

   sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_hit_cnt (
      .g_clk (g_clk),
      .g_clr (g_clr),
      .inc   (hit_inc),
      .count (hit_cnt)
   );

   sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_miss_cnt (
      .g_clk (g_clk),
      .g_clr (g_clr),
      .inc   (miss_inc),
      .count (miss_cnt)
   );

endmodule

// File: tb/tb_dm_cache.sv
// Scoreboard bench for dm_cache (LINES=4, CNT_WIDTH=2, 2-cycle backing RAM).
module tb_dm_cache;

   logic        g_clk;
   logic        g_clr;
   logic [7:0]  cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_re;
   logic        cpu_we;
   logic [15:0] cpu_rdata;
   logic        odv;
   logic        flush;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_re;
   logic        mem_we;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic [1:0]  hit_cnt;
   logic [1:0]  miss_cnt;

   dm_cache #(
      .D_WIDTH   (16),
      .A_WIDTH   (8),
      .LINES     (4),
      .CNT_WIDTH (2)
   ) dut (
      .g_clk     (g_clk),
      .g_clr     (g_clr),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_re    (cpu_re),
      .cpu_we    (cpu_we),
      .cpu_rdata (cpu_rdata),
      .odv       (odv),
      .flush     (flush),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   // Backing RAM: ack on the second strobed cycle.
   logic [15:0] mem [256];
   int          lat;

   assign mem_ack   = (mem_re || mem_we) && (lat == 1);
   assign mem_rdata = mem[mem_addr];

   always @(posedge g_clk) begin
      if ((mem_re || mem_we) && !mem_ack) lat <= lat + 1;
      else lat <= 0;
      if (mem_we && mem_ack) mem[mem_addr] <= mem_wdata;
   end

   typedef struct {
      logic        rd;
      logic [15:0] data;
      string       name;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // Monitor: every completion pops one expectation.
   always @(negedge g_clk) begin
      if (odv) begin
         if (q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_odv: got odv=1, required no completion");
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.rd) begin
               checks++;
               if (cpu_rdata !== e.data) begin
                  errors++;
                  $display("FAIL %s: rdata got %h, required %h", e.name, cpu_rdata, e.data);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      g_clr = 1'b1;
      @(posedge g_clk);
      @(posedge g_clk);
      #1 g_clr = 1'b0;
   endtask

   task automatic flush_pulse();
      flush = 1'b1;
      @(posedge g_clk);
      #1 flush = 1'b0;
   endtask

   // Issue one request (called 1 time unit after a rising edge) and hold it until odv.
   task automatic access(input logic we, input logic re, input logic [7:0] addr,
                         input logic [15:0] wd, input logic [15:0] exp_data,
                         input logic flush_ack, input string name,
                         output int re_cyc, output int we_cyc);
      exp_t e;
      bit   seen;
      e.rd   = !we;
      e.data = exp_data;
      e.name = name;
      q.push_back(e);
      re_cyc    = 0;
      we_cyc    = 0;
      seen      = 0;
      cpu_we    = we;
      cpu_re    = re;
      cpu_addr  = addr;
      cpu_wdata = wd;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge g_clk);
         if (mem_re) re_cyc++;
         if (mem_we) begin
            we_cyc++;
            chk({name, "_mem_waddr"}, {24'd0, mem_addr}, {24'd0, addr});
            chk({name, "_mem_wdata"}, {16'd0, mem_wdata}, {16'd0, wd});
         end
         if (flush_ack && mem_ack) flush = 1'b1;
         if (odv) seen = 1;
         @(posedge g_clk);
         #1 flush = 1'b0;
      end
      if (!seen) begin
         errors++;
         checks++;
         $display("FAIL %s_timeout: got no odv in 20 cycles, required odv", name);
         if (q.size() > 0) q.delete(0);
      end
      cpu_re = 1'b0;
      cpu_we = 1'b0;
   endtask

   int rc;
   int wc;

   initial begin
      foreach (mem[i]) mem[i] = 16'h0000;
      mem[8'h05] = 16'h1234;
      mem[8'h09] = 16'h9999;
      mem[8'h20] = 16'h2020;
      mem[8'h06] = 16'h0606;
      mem[8'h07] = 16'h0707;
      mem[8'h11] = 16'h1111;
      mem[8'h30] = 16'h3030;
      lat       = 0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      cpu_re    = 1'b0;
      cpu_we    = 1'b0;
      flush     = 1'b0;

      // Reset state
      do_reset();
      chk("rst_mem_re", {31'd0, mem_re}, 0);
      chk("rst_mem_we", {31'd0, mem_we}, 0);
      chk("rst_odv", {31'd0, odv}, 0);
      chk("rst_rdata", {16'd0, cpu_rdata}, 0);
      chk("rst_hit_cnt", {30'd0, hit_cnt}, 0);
      chk("rst_miss_cnt", {30'd0, miss_cnt}, 0);

      // Miss then hit
      access(1'b0, 1'b1, 8'h05, 16'h0, 16'h1234, 1'b0, "miss_05", rc, wc);
      chk("miss_05_re_cycles", rc, 2);
      chk("miss_05_miss_cnt", {30'd0, miss_cnt}, 1);
      access(1'b0, 1'b1, 8'h05, 16'h0, 16'h1234, 1'b0, "hit_05", rc, wc);
      chk("hit_05_re_cycles", rc, 0);
      chk("hit_05_hit_cnt", {30'd0, hit_cnt}, 1);

      // Conflict on index 1
      do_reset();
      access(1'b0, 1'b1, 8'h05, 16'h0, 16'h1234, 1'b0, "conf_05a", rc, wc);
      access(1'b0, 1'b1, 8'h09, 16'h0, 16'h9999, 1'b0, "conf_09", rc, wc);
      chk("conf_09_re_cycles", rc, 2);
      access(1'b0, 1'b1, 8'h05, 16'h0, 16'h1234, 1'b0, "conf_05b", rc, wc);
      chk("conf_05b_re_cycles", rc, 2);
      chk("conf_miss_cnt", {30'd0, miss_cnt}, 3);
      chk("conf_hit_cnt", {30'd0, hit_cnt}, 0);

      // Write-through hit, then no-allocate write miss
      access(1'b1, 1'b0, 8'h05, 16'hBEEF, 16'h0, 1'b0, "wr_05", rc, wc);
      chk("wr_05_we_cycles", wc, 2);
      chk("wr_05_re_cycles", rc, 0);
      chk("wr_05_hit_cnt", {30'd0, hit_cnt}, 0);
      access(1'b0, 1'b1, 8'h05, 16'h0, 16'hBEEF, 1'b0, "rd_05_after_wr", rc, wc);
      chk("rd_05_after_wr_re_cycles", rc, 0);
      access(1'b1, 1'b0, 8'h20, 16'hABCD, 16'h0, 1'b0, "wr_20", rc, wc);
      access(1'b0, 1'b1, 8'h20, 16'h0, 16'hABCD, 1'b0, "rd_20", rc, wc);
      chk("rd_20_re_cycles", rc, 2);

      // Flush in idle and flush in the fill ack cycle
      access(1'b0, 1'b1, 8'h05, 16'h0, 16'hBEEF, 1'b0, "pre_flush_05", rc, wc);
      chk("pre_flush_05_re_cycles", rc, 0);
      flush_pulse();
      access(1'b0, 1'b1, 8'h05, 16'h0, 16'hBEEF, 1'b0, "post_flush_05", rc, wc);
      chk("post_flush_05_re_cycles", rc, 2);
      access(1'b0, 1'b1, 8'h06, 16'h0, 16'h0606, 1'b1, "fill_flush_06", rc, wc);
      chk("fill_flush_06_re_cycles", rc, 2);
      access(1'b0, 1'b1, 8'h06, 16'h0, 16'h0606, 1'b0, "reread_06", rc, wc);
      chk("reread_06_re_cycles", rc, 2);

      // Hit counter saturation
      do_reset();
      access(1'b0, 1'b1, 8'h07, 16'h0, 16'h0707, 1'b0, "sat_fill", rc, wc);
      access(1'b0, 1'b1, 8'h07, 16'h0, 16'h0707, 1'b0, "sat_hit1", rc, wc);
      chk("sat_hit_cnt1", {30'd0, hit_cnt}, 1);
      access(1'b0, 1'b1, 8'h07, 16'h0, 16'h0707, 1'b0, "sat_hit2", rc, wc);
      chk("sat_hit_cnt2", {30'd0, hit_cnt}, 2);
      access(1'b0, 1'b1, 8'h07, 16'h0, 16'h0707, 1'b0, "sat_hit3", rc, wc);
      chk("sat_hit_cnt3", {30'd0, hit_cnt}, 3);
      access(1'b0, 1'b1, 8'h07, 16'h0, 16'h0707, 1'b0, "sat_hit4", rc, wc);
      chk("sat_hit_cnt4", {30'd0, hit_cnt}, 3);
      chk("sat_miss_cnt", {30'd0, miss_cnt}, 1);

      // Reset in the middle of a fill
      cpu_addr = 8'h30;
      cpu_re   = 1'b1;
      @(posedge g_clk);
      #1;
      @(negedge g_clk);
      chk("abort_mem_re_before", {31'd0, mem_re}, 1);
      g_clr = 1'b1;
      @(posedge g_clk);
      #1;
      chk("abort_mem_re_after", {31'd0, mem_re}, 0);
      g_clr  = 1'b0;
      cpu_re = 1'b0;
      @(posedge g_clk);
      #1;
      access(1'b0, 1'b1, 8'h30, 16'h0, 16'h3030, 1'b0, "after_abort_30", rc, wc);
      chk("after_abort_30_re_cycles", rc, 2);
      chk("after_abort_miss_cnt", {30'd0, miss_cnt}, 1);

      // Read and write together: treated as a write
      access(1'b1, 1'b1, 8'h11, 16'h7777, 16'h0, 1'b0, "prio_11", rc, wc);
      chk("prio_11_we_cycles", wc, 2);
      chk("prio_11_re_cycles", rc, 0);
      chk("prio_11_miss_cnt", {30'd0, miss_cnt}, 1);
      access(1'b0, 1'b1, 8'h11, 16'h0, 16'h7777, 1'b0, "rd_11", rc, wc);
      chk("rd_11_re_cycles", rc, 2);

      @(posedge g_clk);
      chk("scoreboard_empty", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dm_cache.md
Name: dm_cache

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate cache.
- Placed between the pipeline (instruction fetch or data stage) and a backing RAM. The same block is used for both caches, with different parameters.
- Generalises the fixed 4-line cache: width, address size and line count are parameters. Adds a handshaked memory side, flush, and hit/miss counters.
- odv tells the controller when a request has completed.

Parameters:
- D_WIDTH, 16, data word width in bits.
- A_WIDTH, 8, address width in bits.
- LINES, 4, number of one-word lines. Must be a power of 2 and ≥2.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- g_clk  in  1  clock; all state changes on the rising edge.
- g_clr  in  1  synchronous active-high reset.
- cpu_addr  in  A_WIDTH  request address.
- cpu_wdata  in  D_WIDTH  write data.
- cpu_re  in  1  read request.
- cpu_we  in  1  write request.
- cpu_rdata  out  D_WIDTH  read data; valid only while odv=1 for a read.
- odv  out  1  request complete.
- flush  in  1  invalidate all lines.
- mem_addr  out  A_WIDTH  backing RAM address.
- mem_wdata  out  D_WIDTH  backing RAM write data.
- mem_re  out  1  backing RAM read strobe.
- mem_we  out  1  backing RAM write strobe.
- mem_rdata  in  D_WIDTH  backing RAM read data.
- mem_ack  in  1  backing RAM access done; mem_rdata is valid in the same cycle.
- hit_cnt  out  CNT_WIDTH  count of read hits.
- miss_cnt  out  CNT_WIDTH  count of read misses.

Behaviour:
- Address split: index = cpu_addr[log2(LINES)-1:0]; tag = remaining upper bits.
- Storage: each line holds valid, tag and data. Tag/data arrays are not reset; valid bits are reset.
- Reset (g_clr=1 at an edge): all valid bits=0, state=IDLE, both counters=0. The following are all 0 in the cycle after reset: mem_re, mem_we, odv, cpu_rdata (zero when odv=0).
- Reset during FILL or WRITE: the access is abandoned, strobes drop at that edge, and no line is updated.
- Request hold rule: the requester holds cpu_addr, cpu_wdata, cpu_re and cpu_we stable until it sees odv=1. The block does not latch requests.
- Priority: if cpu_we and cpu_re are both high, the access is treated as a write.

FSM has three states: IDLE, FILL, WRITE.
- IDLE, read hit (valid and tag match):
  - odv=1 combinationally in the same cycle; cpu_rdata = line data.
  - hit_cnt increments at the edge.
  - Zero-cycle latency.
- IDLE, read miss:
  - odv=0; move to FILL.
  - miss_cnt increments once, at the transition.
- FILL:
  - mem_re=1, mem_addr=cpu_addr.
  - On mem_ack: odv=1 and cpu_rdata=mem_rdata in that same cycle.
  - At the edge: write the line (data and tag), set valid=1, go to IDLE.
  - Total miss latency = memory latency + 1 cycle.
- IDLE, write: move to WRITE; odv=0.
- WRITE:
  - mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - On mem_ack: odv=1.
  - At the edge: if the address hits, update the line data. A miss leaves the cache untouched (no write-allocate). Go to IDLE.
  - Writes do not affect the counters.
- Flush:
  - Clears all valid bits at the edge, in any state.
  - If flush coincides with a FILL completion, the fill data is still returned to the requester but the line stays invalid.
  - Flush has no effect on the FSM state.
- Counters saturate at all-ones and do not wrap.
- The memory side is never strobed in IDLE. mem_re and mem_we are never high together.
- Back-to-back: a new request presented the cycle after odv is serviced normally. A read that immediately follows a fill of the same address hits.

Decomposition:
- Shared package (cache_pkg): state encoding constants ST_IDLE=2'd0, ST_FILL=2'd1, ST_WRITE=2'd2, and a clog2 function for index width.
- One natural sub-module: sat_counter (parameter width; ports g_clk, g_clr, inc, count).
  - Instantiate it twice, for hits and for misses.
  - The line storage stays inline.

Test Plan:
- Reset, then read 0x05 with memory returning 0x1234 after 2-cycle ack → miss:
  - mem_re high for 2 cycles; odv with 0x1234 in the ack cycle; miss_cnt=1.
  - Re-reading 0x05 gives odv in the same cycle with 0x1234; hit_cnt=1.
- Conflict with LINES=4:
  - Fill 0x05, then read 0x09 (same index 1, different tag) → miss; line replaced.
  - Re-read 0x05 → miss again; miss_cnt=3.
- Write 0x05=0xBEEF after it is cached:
  - mem_we with mem_addr=0x05 and mem_wdata=0xBEEF until ack.
  - Subsequent read hits with 0xBEEF.
  - A write to uncached 0x20 does not allocate: the next read of 0x20 misses.
- Flush:
  - Flush after caching 0x05 → the next read of 0x05 misses.
  - Flush asserted in the FILL ack cycle → data is returned, but the next read still misses.
- Counter saturation with CNT_WIDTH=2: four hits on a cached line → hit_cnt=3 and stays 3.
- Reset and priority:
  - g_clr in the middle of a FILL (before ack) → mem_re=0 next cycle; the line remains invalid.
  - cpu_re and cpu_we both high → only mem_we is strobed.
